tlb_op_ctrl: RTL and testbench
==============================

Name: tlb_op_ctrl

Overview:
- Sequences the privileged TLB instructions TLBP, TLBR, TLBWI and TLBWR, issued from the WB stage, against the single-ported TLB array.
- Shares the TLB search port with the data-side MMU, with a bounded-starvation arbiter.
- Builds write entries from the CP0 EntryHi/EntryLo0/EntryLo1/Index/Random values.
- Returns results to cp0 as one-cycle tlbr_req/tlbr_res and tlbp_req/tlbp_res pulses.

Parameters:
- TLB_ENTRIES, 16, number of TLB entries.
- IDX_W, $clog2(TLB_ENTRIES), index width.
- STARVE_LIMIT, 4, cycles a pending TLBP waits for the search port before the controller forces the grant.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- op_valid  in  1  TLB instruction present in WB; held high until op_done.
- op  in  TlbOp_t(2)  0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR.
- op_done  out  1  one-cycle completion pulse.
- busy  out  1  high while state != IDLE; pipeline stall source.
- cp0_index, cp0_random, cp0_entry_hi, cp0_entry_lo0, cp0_entry_lo1  in  32 each  current CP0 values.
- tlb_we  out  1  TLB write strobe.
- tlb_widx  out  IDX_W  write index.
- tlb_wentry  out  TLBEntry_t  write data.
- tlb_ridx  out  IDX_W  read index.
- tlb_rentry  in  TLBEntry_t  read data, valid one cycle after tlb_ridx is presented.
- dmmu_req  in  1  data MMU search request.
- dmmu_vpn2  in  19  data MMU search key.
- dmmu_asid  in  8  data MMU search ASID.
- dmmu_gnt  out  1  data MMU owns the search port this cycle.
- srch_vpn2  out  19  muxed search key.
- srch_asid  out  8  muxed search ASID.
- srch_hit  in  1  search result, one cycle after the key.
- srch_idx  in  IDX_W  search result index, one cycle after the key.
- tlbr_req  out  1  TLBR result pulse to cp0.
- tlbr_res  out  TLBEntry_t  TLBR result entry.
- tlbp_req  out  1  TLBP result pulse to cp0.
- tlbp_res  out  32  TLBP result word.

Behaviour:
- Reset: state=IDLE, starve counter=0. All outputs 0: busy, op_done, tlb_we, tlbr_req, tlbp_req, tlbp_res, tlb_widx, tlb_ridx. Reset mid-operation abandons the op with no TLB write and no cp0 pulse.
- FSM states: IDLE, READ, RDONE, SEARCH, PRES, WRITE.
- IDLE + op_valid: latch op, entry_hi, entry_lo0/1, cp0_index[IDX_W-1:0] and cp0_random[IDX_W-1:0]. Next state: TLBR->READ, TLBP->SEARCH, TLBWI/TLBWR->WRITE.
- op_valid is ignored in the cycle immediately after op_done, which prevents re-issue.
- WRITE (1 cycle): tlb_we=1 and op_done=1, then IDLE.
  - tlb_widx = latched Index for TLBWI, latched Random for TLBWR.
  - Entry fields: vpn2=hi[31:13], asid=hi[7:0], G=lo0[0]&lo1[0].
  - pfnN=loN[25:6], cN=loN[5:3], dN=loN[2], vN=loN[1].
  - TLBWI latency: op_valid cycle 0, write and op_done cycle 1.
- READ: tlb_ridx = latched Index, then RDONE.
- RDONE: tlbr_res = tlb_rentry, tlbr_req=1, op_done=1, then IDLE. TLBR latency is 2 cycles.
- SEARCH, arbitration:
  - If dmmu_req=1 and starve counter < STARVE_LIMIT: dmmu_gnt=1, search key = dmmu key, counter increments, stay in SEARCH.
  - Otherwise: dmmu_gnt=0, search key = latched vpn2/asid, counter clears, go to PRES.
- PRES: tlbp_req=1, op_done=1, then IDLE.
  - tlbp_res = srch_hit ? {(32-IDX_W)'0, srch_idx} : 32'h8000_0000.
- Outside SEARCH: dmmu_gnt=dmmu_req and the search key is the dmmu key. The data MMU always wins when no TLBP is pending.
- Worst-case TLBP latency is STARVE_LIMIT+2 cycles.
- tlb_we is never asserted outside WRITE.
- tlbr_req and tlbp_req are never high in the same cycle.
- Index and Random are truncated to IDX_W bits. No range check is done, since TLB_ENTRIES is a power of 2.

Decomposition:
- Shared cpu_defs package: TlbOp_t enum, TLBEntry_t (already shared), TLB_ENTRIES, and the EntryLo field bit positions.
- One natural sub-module, tlb_search_arb, holding the starvation counter and the search-port mux.

Test Plan:
- TLBWI, Index=5, hi=32'h0040_2012, lo0=32'h0000_1047, lo1=32'h0000_1087 -> cycle 1: tlb_we=1, widx=5, vpn2=19'h201, asid=8'h12, G=1, pfn0=20'h41, pfn1=20'h42. op_done=1 in the same cycle.
- TLBWR with Random=11 -> widx=11. A change of Random after the latch cycle has no effect.
- TLBR with Index=3, array entry 3 preloaded -> tlbr_req one pulse on cycle 2, tlbr_res equals the entry, op_done coincident.
- TLBP with no dmmu_req, srch_hit=1, srch_idx=7 -> tlbp_res=32'h7 on cycle 2. Repeat with a miss -> tlbp_res=32'h8000_0000.
- TLBP with dmmu_req held high -> dmmu_gnt high for exactly 4 cycles, then forced grant. tlbp_req on cycle 6, then dmmu_gnt returns high.
- Assert rst while in SEARCH, then release -> busy=0, no tlbp_req, tlb_we stays 0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: TLB instruction opcodes, the TLB entry layout and
// the EntryLo field positions used to build TLB write data.
package cpu_defs;

  localparam int TLB_ENTRIES = 16;

  localparam int LO_PFN_HI = 25;
  localparam int LO_PFN_LO = 6;
  localparam int LO_C_HI   = 5;
  localparam int LO_C_LO   = 3;
  localparam int LO_D      = 2;
  localparam int LO_V      = 1;
  localparam int LO_G      = 0;

  typedef enum logic [1:0] {
    TLBP  = 2'd0,
    TLBR  = 2'd1,
    TLBWI = 2'd2,
    TLBWR = 2'd3
  } TlbOp_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_RDONE  = 3'd2,
    S_SEARCH = 3'd3,
    S_PRES   = 3'd4,
    S_WRITE  = 3'd5
  } TlbState_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } TLBEntry_t;

  // Global bit is shared by both halves, so it is the AND of the two G bits.
  function automatic TLBEntry_t build_entry(input logic [31:0] hi,
                                            input logic [31:0] lo0,
                                            input logic [31:0] lo1);
    TLBEntry_t e;
    e.vpn2 = hi[31:13];
    e.asid = hi[7:0];
    e.g    = lo0[LO_G] & lo1[LO_G];
    e.pfn0 = lo0[LO_PFN_HI:LO_PFN_LO];
    e.c0   = lo0[LO_C_HI:LO_C_LO];
    e.d0   = lo0[LO_D];
    e.v0   = lo0[LO_V];
    e.pfn1 = lo1[LO_PFN_HI:LO_PFN_LO];
    e.c1   = lo1[LO_C_HI:LO_C_LO];
    e.d1   = lo1[LO_D];
    e.v1   = lo1[LO_V];
    return e;
  endfunction

endpackage

// File: rtl/tlb_op_ctrl_arb.sv
// Search-port arbiter: the data MMU normally owns the port, but a pending
// TLBP is granted after STARVE_LIMIT consecutive data-MMU wins.
module tlb_search_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_search,
  input  logic        i_dmmu_req,
  input  logic [18:0] i_dmmu_vpn2,
  input  logic [7:0]  i_dmmu_asid,
  input  logic [18:0] i_own_vpn2,
  input  logic [7:0]  i_own_asid,
  output logic        o_dmmu_gnt,
  output logic        o_force,
  output logic [18:0] o_srch_vpn2,
  output logic [7:0]  o_srch_asid
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;
  logic             w_dmmu_win;

  always_comb begin
    w_dmmu_win  = i_dmmu_req && (!i_search || (r_cnt < LIMIT));
    o_dmmu_gnt  = w_dmmu_win;
    o_force     = i_search && !w_dmmu_win;
    if (w_dmmu_win) begin
      o_srch_vpn2 = i_dmmu_vpn2;
      o_srch_asid = i_dmmu_asid;
    end else if (i_search) begin
      o_srch_vpn2 = i_own_vpn2;
      o_srch_asid = i_own_asid;
    end else begin
      o_srch_vpn2 = i_dmmu_vpn2;
      o_srch_asid = i_dmmu_asid;
    end
  end

  // Counts data-MMU wins while a TLBP waits; any other cycle restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_search && w_dmmu_win) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR from WB against the single-ported TLB and
// returns results to cp0 as one-cycle pulses.
module tlb_op_ctrl
  import cpu_defs::*;
#(
  parameter int TLB_ENTRIES  = cpu_defs::TLB_ENTRIES,
  parameter int IDX_W        = $clog2(TLB_ENTRIES),
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  TlbOp_t           op,
  output logic             op_done,
  output logic             busy,
  input  logic [31:0]      cp0_index,
  input  logic [31:0]      cp0_random,
  input  logic [31:0]      cp0_entry_hi,
  input  logic [31:0]      cp0_entry_lo0,
  input  logic [31:0]      cp0_entry_lo1,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_widx,
  output TLBEntry_t        tlb_wentry,
  output logic [IDX_W-1:0] tlb_ridx,
  input  TLBEntry_t        tlb_rentry,
  input  logic             dmmu_req,
  input  logic [18:0]      dmmu_vpn2,
  input  logic [7:0]       dmmu_asid,
  output logic             dmmu_gnt,
  output logic [18:0]      srch_vpn2,
  output logic [7:0]       srch_asid,
  input  logic             srch_hit,
  input  logic [IDX_W-1:0] srch_idx,
  output logic             tlbr_req,
  output TLBEntry_t        tlbr_res,
  output logic             tlbp_req,
  output logic [31:0]      tlbp_res
);

  TlbState_t        r_state;
  TlbState_t        w_next;
  TlbOp_t           r_op;
  TLBEntry_t        r_went;
  logic [IDX_W-1:0] r_index;
  logic [IDX_W-1:0] r_random;
  logic             r_done_d;
  logic             w_accept;
  logic             w_force;
  logic             w_unused_bits;

  assign w_unused_bits = ^{cp0_index[31:IDX_W], cp0_random[31:IDX_W],
                           cp0_entry_hi[12:8], cp0_entry_lo0[31:26],
                           cp0_entry_lo1[31:26]};

  // The cycle after op_done still sees op_valid high from WB; do not re-issue.
  assign w_accept = op_valid && !r_done_d && (r_state == S_IDLE);

  tlb_search_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_search    (r_state == S_SEARCH),
    .i_dmmu_req  (dmmu_req),
    .i_dmmu_vpn2 (dmmu_vpn2),
    .i_dmmu_asid (dmmu_asid),
    .i_own_vpn2  (r_went.vpn2),
    .i_own_asid  (r_went.asid),
    .o_dmmu_gnt  (dmmu_gnt),
    .o_force     (w_force),
    .o_srch_vpn2 (srch_vpn2),
    .o_srch_asid (srch_asid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Snapshot of CP0 operands at issue so later CP0 updates cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= TLBP;
      r_went   <= '0;
      r_index  <= '0;
      r_random <= '0;
      r_done_d <= 1'b0;
    end else begin
      r_done_d <= op_done;
      if (w_accept) begin
        r_op     <= op;
        r_went   <= build_entry(cp0_entry_hi, cp0_entry_lo0, cp0_entry_lo1);
        r_index  <= cp0_index[IDX_W-1:0];
        r_random <= cp0_random[IDX_W-1:0];
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_next     = r_state;
    busy       = (r_state != S_IDLE);
    op_done    = 1'b0;
    tlb_we     = 1'b0;
    tlb_widx   = '0;
    tlb_wentry = '0;
    tlb_ridx   = '0;
    tlbr_req   = 1'b0;
    tlbr_res   = '0;
    tlbp_req   = 1'b0;
    tlbp_res   = 32'h0000_0000;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op)
            TLBP:        w_next = S_SEARCH;
            TLBR:        w_next = S_READ;
            TLBWI, TLBWR: w_next = S_WRITE;
            default:     w_next = S_IDLE;
          endcase
        end else begin
          w_next = S_IDLE;
        end
      end
      S_READ: begin
        tlb_ridx = r_index;
        w_next   = S_RDONE;
      end
      S_RDONE: begin
        tlbr_req = 1'b1;
        tlbr_res = tlb_rentry;
        op_done  = 1'b1;
        w_next   = S_IDLE;
      end
      S_SEARCH: begin
        if (w_force) begin
          w_next = S_PRES;
        end else begin
          w_next = S_SEARCH;
        end
      end
      S_PRES: begin
        tlbp_req = 1'b1;
        op_done  = 1'b1;
        if (srch_hit) begin
          tlbp_res = {{(32-IDX_W){1'b0}}, srch_idx};
        end else begin
          tlbp_res = 32'h8000_0000;
        end
        w_next = S_IDLE;
      end
      S_WRITE: begin
        tlb_we     = 1'b1;
        op_done    = 1'b1;
        tlb_widx   = (r_op == TLBWR) ? r_random : r_index;
        tlb_wentry = r_went;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: expected TLB writes and cp0 pulses are
// queued at issue and compared when the controller produces them.
module tb_tlb_op_ctrl;
  import cpu_defs::*;

  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             op_valid;
  TlbOp_t           op;
  logic             op_done, busy;
  logic [31:0]      cp0_index, cp0_random, cp0_entry_hi, cp0_entry_lo0, cp0_entry_lo1;
  logic             tlb_we;
  logic [IDX_W-1:0] tlb_widx, tlb_ridx;
  TLBEntry_t        tlb_wentry, tlb_rentry, tlbr_res;
  logic             dmmu_req, dmmu_gnt;
  logic [18:0]      dmmu_vpn2, srch_vpn2;
  logic [7:0]       dmmu_asid, srch_asid;
  logic             srch_hit;
  logic [IDX_W-1:0] srch_idx;
  logic             tlbr_req, tlbp_req;
  logic [31:0]      tlbp_res;

  tlb_op_ctrl #(.TLB_ENTRIES(16), .IDX_W(IDX_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_done(op_done), .busy(busy),
    .cp0_index(cp0_index), .cp0_random(cp0_random), .cp0_entry_hi(cp0_entry_hi),
    .cp0_entry_lo0(cp0_entry_lo0), .cp0_entry_lo1(cp0_entry_lo1),
    .tlb_we(tlb_we), .tlb_widx(tlb_widx), .tlb_wentry(tlb_wentry),
    .tlb_ridx(tlb_ridx), .tlb_rentry(tlb_rentry),
    .dmmu_req(dmmu_req), .dmmu_vpn2(dmmu_vpn2), .dmmu_asid(dmmu_asid), .dmmu_gnt(dmmu_gnt),
    .srch_vpn2(srch_vpn2), .srch_asid(srch_asid), .srch_hit(srch_hit), .srch_idx(srch_idx),
    .tlbr_req(tlbr_req), .tlbr_res(tlbr_res), .tlbp_req(tlbp_req), .tlbp_res(tlbp_res)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [127:0] val;
    logic [3:0]   idx;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  exp_t pq[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  TLBEntry_t   mem [16];
  TLBEntry_t   last_we;
  logic        hit_en;
  logic [18:0] want_vpn2;
  logic [7:0]  want_asid;
  logic [3:0]  want_idx;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic TLBEntry_t mk_entry(input logic [31:0] hi, input logic [31:0] lo0,
                                         input logic [31:0] lo1);
    TLBEntry_t e;
    e = '{vpn2: hi[31:13], asid: hi[7:0], g: lo0[0] & lo1[0],
          pfn0: lo0[25:6], c0: lo0[5:3], d0: lo0[2], v0: lo0[1],
          pfn1: lo1[25:6], c1: lo1[5:3], d1: lo1[2], v1: lo1[1]};
    return e;
  endfunction

  // TLB array and search CAM models, both one cycle of latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tlb_we) mem[tlb_widx] <= tlb_wentry;
    tlb_rentry <= mem[tlb_ridx];
    srch_hit   <= hit_en && (srch_vpn2 == want_vpn2) && (srch_asid == want_asid);
    srch_idx   <= want_idx;
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (tlb_we) begin
        last_we = tlb_wentry;
        if (wq.size() == 0) check("unexp_we", {127'd0, tlb_we}, 128'd0);
        else begin
          e = wq.pop_front();
          check("we_cyc", 128'(cyc), 128'(e.cyc));
          check("widx", 128'(tlb_widx), 128'(e.idx));
          check("wentry", 128'(tlb_wentry), e.val);
        end
      end
      if (tlbr_req) begin
        if (rq.size() == 0) check("unexp_tlbr", {127'd0, tlbr_req}, 128'd0);
        else begin
          e = rq.pop_front();
          check("tlbr_cyc", 128'(cyc), 128'(e.cyc));
          check("tlbr_res", 128'(tlbr_res), e.val);
        end
      end
      if (tlbp_req) begin
        if (pq.size() == 0) check("unexp_tlbp", {127'd0, tlbp_req}, 128'd0);
        else begin
          e = pq.pop_front();
          check("tlbp_cyc", 128'(cyc), 128'(e.cyc));
          check("tlbp_res", 128'(tlbp_res), e.val);
        end
      end
      if (op_done || tlb_we || tlbr_req || tlbp_req) begin
        check("op_done", {127'd0, op_done}, {127'd0, tlb_we | tlbr_req | tlbp_req});
        check("req_excl", {127'd0, tlbr_req & tlbp_req}, 128'd0);
      end
    end
  end

  task automatic issue(input TlbOp_t o, input logic [31:0] idx, input logic [31:0] rnd,
                       input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1,
                       input int lat, input logic [127:0] val, input logic [3:0] eidx,
                       input bit hold_extra);
    exp_t e;
    bit   done;
    @(negedge clk);
    op = o; cp0_index = idx; cp0_random = rnd;
    cp0_entry_hi = hi; cp0_entry_lo0 = lo0; cp0_entry_lo1 = lo1;
    op_valid = 1'b1;
    e.cyc = cyc + lat; e.val = val; e.idx = eidx;
    case (o)
      TLBR:    rq.push_back(e);
      TLBP:    pq.push_back(e);
      default: wq.push_back(e);
    endcase
    @(posedge clk); #1;
    cp0_index = $urandom; cp0_random = $urandom;
    cp0_entry_hi = $urandom; cp0_entry_lo0 = $urandom; cp0_entry_lo1 = $urandom;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (op_done) done = 1'b1;
    end
    if (!done) check("op_timeout", {127'd0, op_done}, 128'd1);
    if (hold_extra) @(negedge clk);
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    TLBEntry_t e1, e2;
    rst = 1'b1; op_valid = 1'b0; op = TLBP;
    cp0_index = 32'd0; cp0_random = 32'd0; cp0_entry_hi = 32'd0;
    cp0_entry_lo0 = 32'd0; cp0_entry_lo1 = 32'd0;
    dmmu_req = 1'b0; dmmu_vpn2 = 19'h0; dmmu_asid = 8'h0;
    hit_en = 1'b0; want_vpn2 = 19'h0; want_asid = 8'h0; want_idx = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_outs", 128'({busy, op_done, tlb_we, tlbr_req, tlbp_req, tlbp_res, tlb_widx, tlb_ridx}),
          128'd0);
    rst = 1'b0;
    @(negedge clk);

    // TLBWI to index 5, held one extra cycle to prove no re-issue.
    e1 = mk_entry(32'h0040_2012, 32'h0000_1047, 32'h0000_1087);
    issue(TLBWI, 32'd5, 32'd9, 32'h0040_2012, 32'h0000_1047, 32'h0000_1087, 1, 128'(e1), 4'd5, 1'b1);
    check("wi_vpn2", 128'(last_we.vpn2), 128'h201);
    check("wi_asid", 128'(last_we.asid), 128'h12);
    check("wi_g",    128'(last_we.g),    128'd1);
    check("wi_pfn0", 128'(last_we.pfn0), 128'h41);
    check("wi_pfn1", 128'(last_we.pfn1), 128'h42);

    // TLBWR to Random=11.
    e2 = mk_entry(32'hABCD_E0FF, 32'h03FF_FFFE, 32'h0123_4569);
    issue(TLBWR, 32'd2, 32'd11, 32'hABCD_E0FF, 32'h03FF_FFFE, 32'h0123_4569, 1, 128'(e2), 4'd11, 1'b0);

    // Preload entry 3 by TLBWI (upper Index bits must be ignored), then read it back.
    e2 = mk_entry(32'h1234_5677, 32'h0000_0F2D, 32'h0200_0033);
    issue(TLBWI, 32'hFFFF_FFF3, 32'd0, 32'h1234_5677, 32'h0000_0F2D, 32'h0200_0033, 1, 128'(e2), 4'd3, 1'b0);
    issue(TLBR, 32'd3, 32'd7, 32'h0, 32'h0, 32'h0, 2, 128'(e2), 4'd0, 1'b0);
    issue(TLBR, 32'd5, 32'd7, 32'h0, 32'h0, 32'h0, 2, 128'(e1), 4'd0, 1'b0);

    // TLBP hit at 7, then a miss.
    hit_en = 1'b1; want_vpn2 = 19'h2_3456; want_asid = 8'h5A; want_idx = 4'd7;
    issue(TLBP, 32'd0, 32'd0, {19'h2_3456, 5'd0, 8'h5A}, 32'h0, 32'h0, 2, 128'h7, 4'd0, 1'b0);
    issue(TLBP, 32'd0, 32'd0, {19'h2_3457, 5'd0, 8'h5A}, 32'h0, 32'h0, 2, 128'h8000_0000, 4'd0, 1'b0);

    // TLBP against a continuously requesting data MMU.
    want_idx = 4'd9; dmmu_vpn2 = 19'h1_1111; dmmu_asid = 8'h22; dmmu_req = 1'b1;
    fork
      issue(TLBP, 32'd0, 32'd0, {19'h2_3456, 5'd0, 8'h5A}, 32'h0, 32'h0, 6, 128'h9, 4'd0, 1'b0);
      begin
        @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
          @(negedge clk);
          check($sformatf("gnt_c%0d", i), {127'd0, dmmu_gnt}, {127'd0, (i != 5)});
          if (i == 5) check("forced_key", 128'(srch_vpn2), 128'h2_3456);
        end
      end
    join
    dmmu_req = 1'b0;

    // Reset while in SEARCH abandons the TLBP.
    dmmu_req = 1'b1;
    @(negedge clk);
    op = TLBP; cp0_entry_hi = 32'h0; op_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("busy_search", {127'd0, busy}, 128'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", 128'({busy, op_done, tlb_we, tlbp_req, tlbp_res}), 128'd0);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst", 128'({busy, tlbp_req, tlb_we}), 128'd0);
    end
    dmmu_req = 1'b0;

    check("wq_left", 128'(wq.size()), 128'd0);
    check("rq_left", 128'(rq.size()), 128'd0);
    check("pq_left", 128'(pq.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
